// File: rtl/mux_n_to_1_rr_pkg.sv
// Shared constants for the N-to-1 channel multiplexer: mode encodings, output
// register states and the select-width helper.
package mux_n_to_1_rr_pkg;

    localparam logic MUX_MODE_MANUAL = 1'b0;
    localparam logic MUX_MODE_RR     = 1'b1;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    // ceil(log2(n)) with a floor of 1 so a 2-channel select is still one bit wide
    function automatic int unsigned mux_clog2(input int unsigned n);
        for (int unsigned w = 1; w < 32; w++) begin
            if ((32'd1 << w) >= n) begin
                return w;
            end
        end
        return 32;
    endfunction

endpackage

// File: rtl/mux_n_to_1_rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester after ptr, wrapping
// modulo N. Purely combinational, grant is one-hot or zero.
module mux_n_to_1_rr_arbiter
    import mux_n_to_1_rr_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned PTR_W = mux_clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    always_comb begin
        int unsigned idx;
        logic        found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx = (32'(ptr) + off) % N;
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && (i == idx) && req[i]) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_n_to_1_rr.sv
// Registered N-to-1 channel multiplexer with valid/ready handshake, manual or
// round-robin selection. Define MUXN_CH_TAG_EN to add the out_ch source tag.
module mux_n_to_1_rr
    import mux_n_to_1_rr_pkg::*;
#(
    parameter  int unsigned N_CH   = 4,
    parameter  int unsigned DATA_W = 8,
    localparam int unsigned SEL_W  = mux_clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef MUXN_CH_TAG_EN
    ,
    output logic [SEL_W-1:0]         out_ch
`endif
);

    logic [N_CH-1:0]   man_gnt;
    logic [N_CH-1:0]   rr_gnt;
    logic [N_CH-1:0]   grant;
    logic [SEL_W-1:0]  gnt_idx;
    logic [DATA_W-1:0] gnt_data;
    logic              load;
    logic              xfer;

    logic              state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

    mux_n_to_1_rr_arbiter #(
        .N (N_CH)
    ) u_arb (
        .req (in_valid),
        .ptr (rr_ptr_q),
        .gnt (rr_gnt)
    );

    // Out-of-range sel matches no channel, so it never forwards data
    always_comb begin
        man_gnt = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            man_gnt[i] = in_valid[i] & (32'(sel) == i);
        end
    end

    assign grant    = (mode == MUX_MODE_RR) ? rr_gnt : man_gnt;
    assign load     = (state_q == ST_EMPTY) | out_ready;
    assign in_ready = grant & {N_CH{load & ~rst}};
    assign xfer     = |in_ready;

    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                gnt_idx  = SEL_W'(i);
                gnt_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            state_d = ST_FULL;
            data_d  = gnt_data;
            if (mode == MUX_MODE_RR) begin
                rr_ptr_d = gnt_idx;
            end
        end else if (out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // rr_ptr starts at the last channel so the first RR scan begins at ch 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            data_q   <= '0;
            rr_ptr_q <= SEL_W'(N_CH - 1);
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef MUXN_CH_TAG_EN
    logic [SEL_W-1:0] ch_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q <= '0;
        end else if (xfer) begin
            ch_q <= gnt_idx;
        end
    end

    assign out_ch = ch_q;
`endif

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;

endmodule

// File: tb/tb_mux_n_to_1_rr.sv
// Directed bench for mux_n_to_1_rr: a 4-channel instance checked through an
// output scoreboard, plus a 3-channel instance for out-of-range select.
module tb_mux_n_to_1_rr;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] ch;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic        out_ready3;
`ifdef MUXN_CH_TAG_EN
    logic [1:0]  out_ch;
    logic [1:0]  out_ch3;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    mux_n_to_1_rr #(
        .N_CH   (4),
        .DATA_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUXN_CH_TAG_EN
        ,
        .out_ch    (out_ch)
`endif
    );

    mux_n_to_1_rr #(
        .N_CH   (3),
        .DATA_W (8)
    ) dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode3),
        .sel       (sel3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
`ifdef MUXN_CH_TAG_EN
        ,
        .out_ch    (out_ch3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch);
        exp_t e;
        e.data = in_data[ch*8 +: 8];
        e.ch   = 2'(ch);
        exp_q.push_back(e);
    endtask

    // Every word the sink accepts must match the oldest expected word
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_t e;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed data=%0h expected no word", out_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_data", 32'(out_data), 32'(e.data));
`ifdef MUXN_CH_TAG_EN
                check("sb_ch", 32'(out_ch), 32'(e.ch));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int order_a[5] = '{0, 1, 2, 3, 0};
        int order_b[4] = '{2, 3, 0, 2};

        rst        = 1'b1;
        mode       = 1'b1;
        sel        = 2'd0;
        in_valid   = 4'hF;
        in_data    = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        out_ready  = 1'b0;
        mode3      = 1'b0;
        sel3       = 2'd0;
        in_data3   = {8'h72, 8'h71, 8'h70};
        in_valid3  = 3'b000;
        out_ready3 = 1'b0;

        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_in_ready", 32'(in_ready), 0);
`ifdef MUXN_CH_TAG_EN
        check("rst_out_ch", 32'(out_ch), 0);
`endif

        // Round-robin from reset, all channels valid
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        foreach (order_a[k]) begin
            check("rr_all_grant", 32'(in_ready), 32'd1 << order_a[k]);
            push(order_a[k]);
            tick();
        end
        in_valid = 4'b1101;
        #1;
        foreach (order_b[k]) begin
            check("rr_drop1_grant", 32'(in_ready), 32'd1 << order_b[k]);
            push(order_b[k]);
            tick();
        end

        // Backpressure: held word must not follow the source
        out_ready         = 1'b0;
        in_data[23:16]    = 8'h5A;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_out_data", 32'(out_data), 32'hC2);
            check("bp_out_valid", 32'(out_valid), 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_same_cycle_load", 32'(in_ready), 32'b1000);
        push(3);
        tick();
        check("bp_next_word", 32'(out_data), 32'hC3);
        in_valid = 4'b0000;
        tick();
        check("drain_out_valid", 32'(out_valid), 0);
        check("drain_keep_data", 32'(out_data), 32'hC3);

        // Manual mode, sel=2
        mode           = 1'b0;
        sel            = 2'd2;
        in_data[23:16] = 8'hA5;
        in_valid       = 4'b0100;
        #1;
        check("man_in_ready", 32'(in_ready), 32'b0100);
        push(2);
        tick();
        check("man_out_data", 32'(out_data), 32'hA5);
        check("man_out_valid", 32'(out_valid), 1);
        in_valid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            in_data[23:16] = 8'hA6 + 8'(k);
            #1;
            check("man_only_sel", 32'(in_ready), 32'b0100);
            push(2);
            tick();
        end
        // Manual transfers leave rr_ptr at ch3
        mode = 1'b1;
        #1;
        check("rr_ptr_kept", 32'(in_ready), 32'b0001);
        push(0);
        tick();
        in_valid = 4'b0000;
        tick();
        check("drain2_out_valid", 32'(out_valid), 0);

        // Mode switch while FULL
        out_ready = 1'b0;
        in_valid  = 4'hF;
        #1;
        check("ms_rr_grant", 32'(in_ready), 32'b0010);
        push(1);
        tick();
        mode = 1'b0;
        sel  = 2'd3;
        #1;
        check("ms_hold_ready", 32'(in_ready), 0);
        tick();
        check("ms_hold_data", 32'(out_data), 32'hC1);
`ifdef MUXN_CH_TAG_EN
        check("ms_hold_ch", 32'(out_ch), 1);
`endif
        out_ready = 1'b1;
        #1;
        check("ms_next_sel", 32'(in_ready), 32'b1000);
        push(3);
        tick();
        in_valid = 4'b0000;
        tick();
        check("drain3_out_valid", 32'(out_valid), 0);

        // Reset mid-stream discards the held word
        mode      = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b0;
        tick();
        check("mid_pre_valid", 32'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_data", 32'(out_data), 0);
        check("mid_rst_ready", 32'(in_ready), 0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_ch0", 32'(in_ready), 32'b0001);
        push(0);
        tick();
        in_valid = 4'b0000;
        tick();
        check("drain4_out_valid", 32'(out_valid), 0);

        // Three channels: sel=3 is out of range
        in_valid3  = 3'b111;
        out_ready3 = 1'b1;
        #1;
        check("n3_sel0_ready", 32'(in_ready3), 32'b001);
        tick();
        check("n3_sel0_data", 32'(out_data3), 32'h70);
        check("n3_sel0_valid", 32'(out_valid3), 1);
        sel3 = 2'd3;
        #1;
        check("n3_oor_ready", 32'(in_ready3), 0);
        tick();
        check("n3_oor_drained", 32'(out_valid3), 0);
        check("n3_oor_keep", 32'(out_data3), 32'h70);
        sel3 = 2'd2;
        #1;
        check("n3_sel2_ready", 32'(in_ready3), 32'b100);
        tick();
        check("n3_sel2_data", 32'(out_data3), 32'h72);
`ifdef MUXN_CH_TAG_EN
        check("n3_sel2_ch", 32'(out_ch3), 2);
`endif

        check("sb_leftover", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
